pwm_frame_tx: RTL

PWM_FRAME_TX -- requirements
Module: pwm_frame_tx

---
 rtl/pwm_frame_tx_pkg.sv | 6 +
 rtl/pwm_frame_tx_if.sv | 18 +
 rtl/pwm_frame_tx_phase_cnt.sv | 18 +
 rtl/pwm_frame_tx.sv | 70 +++++++
 4 files changed

// File: rtl/pwm_frame_tx_pkg.sv
// pwm_pkg: FSM state type and default frame timing shared by the PWM frame transmitter.
package pwm_pkg;
    localparam int LOW_W_DEF = 11;
    localparam int HIGH_CLKS_DEF = 25;
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
endpackage

// File: rtl/pwm_frame_tx_if.sv
// pwm_frame_tx_if: request handshake plus generated line and frame status of pwm_frame_tx.
interface pwm_frame_tx_if import pwm_pkg::*; #(parameter int LOW_W = LOW_W_DEF);
    logic [LOW_W-1:0] low_clks_i;
    logic low_valid_i;
    logic low_ready_o;
    logic pwm_out_data_o;
    logic busy_o;
    logic frame_done_o;
    logic [15:0] frame_cnt_o;
    modport master (
        output low_clks_i, low_valid_i,
        input low_ready_o, pwm_out_data_o, busy_o, frame_done_o, frame_cnt_o
    );
    modport slave (
        input low_clks_i, low_valid_i,
        output low_ready_o, pwm_out_data_o, busy_o, frame_done_o, frame_cnt_o
    );
endinterface

// File: rtl/pwm_frame_tx_phase_cnt.sv
// pwm_phase_cnt: loadable down-counter timing one phase; zero_next lets the owner register flags early.
module pwm_phase_cnt #(parameter int W = 11) (
    input logic clk,
    input logic reset,
    input logic load,
    input logic [W-1:0] load_val,
    input logic dec,
    output logic zero,
    output logic zero_next
);
    logic [W-1:0] cnt, cnt_d;
    always_comb cnt_d = load ? load_val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;
    assign zero = cnt == '0;
    assign zero_next = cnt_d == '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= cnt_d;
endmodule

// File: rtl/pwm_frame_tx.sv
// pwm_frame_tx: emits one frame per request -- N clocks low then HIGH_CLKS clocks high -- on a registered line.
module pwm_frame_tx import pwm_pkg::*; #(
    parameter int LOW_W = LOW_W_DEF,
    parameter int HIGH_CLKS = HIGH_CLKS_DEF
) (
    input logic clk,
    input logic reset,
    pwm_frame_tx_if.slave bus
);
    localparam logic [LOW_W-1:0] HIGH_LOAD = LOW_W'(HIGH_CLKS - 1);
    state_t state, state_d, first_state;
    logic accept, load, dec, zero, zero_next, last_d;
    logic [LOW_W-1:0] load_val, first_val;
    assign accept = bus.low_valid_i && bus.low_ready_o;
    // Counter holds cycles remaining minus one, so a phase ends when it reads zero.
    assign first_state = bus.low_clks_i != '0 ? LOW : HIGH;
    assign first_val = bus.low_clks_i != '0 ? bus.low_clks_i - 1'b1 : HIGH_LOAD;
    always_comb begin
        state_d = state;
        load = 1'b0;
        dec = 1'b0;
        load_val = '0;
        case (state)
            IDLE: if (accept) begin
                state_d = first_state;
                load = 1'b1;
                load_val = first_val;
            end
            LOW: if (zero) begin
                state_d = HIGH;
                load = 1'b1;
                load_val = HIGH_LOAD;
            end else dec = 1'b1;
            HIGH: if (!zero) dec = 1'b1;
            else if (accept) begin
                state_d = first_state;
                load = 1'b1;
                load_val = first_val;
            end else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign last_d = state_d == HIGH && zero_next;
    pwm_phase_cnt #(.W(LOW_W)) u_cnt (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .dec(dec),
        .zero(zero),
        .zero_next(zero_next)
    );
    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            bus.pwm_out_data_o <= 1'b1;
            bus.busy_o <= 1'b0;
            bus.low_ready_o <= 1'b0;
            bus.frame_done_o <= 1'b0;
            bus.frame_cnt_o <= '0;
        end else begin
            state <= state_d;
            bus.pwm_out_data_o <= state_d != LOW;
            bus.busy_o <= state_d != IDLE;
            bus.low_ready_o <= state_d == IDLE || last_d;
            bus.frame_done_o <= last_d;
            bus.frame_cnt_o <= bus.frame_cnt_o + 16'(last_d);
        end
endmodule
